// File: rtl/add3_frame_acc_pkg.sv
// Shared definitions for the adder-result frame accumulator: FSM states and
// the helper that turns the adder's latency parameter into its total delay.
package add3_frame_acc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // The upstream adder spends 2*latency cycles from operands to result.
    function automatic int adder_total_latency(input int latency);
        return 2 * latency;
    endfunction

endpackage

// File: rtl/add3_frame_acc_valid_delay.sv
// One-bit shift register that carries a valid tag alongside the adder pipeline,
// with synchronous active-low reset and synchronous flush.
module add3_frame_acc_valid_delay #(
    parameter int DEPTH = 6
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flush,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] tag_sr;

    // NOTE: non-blocking so every stage captures its neighbour's pre-edge value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            tag_sr <= '0;
        end else begin
            tag_sr <= {tag_sr[DEPTH-2:0], i_din};
        end
    end

    assign o_dout = tag_sr[DEPTH-1];

endmodule

// File: rtl/add3_frame_acc.sv
// Sums FRAME_LEN valid adder results per frame and offers each total on a
// valid/ready port backed by a single holding register; blocked totals count as drops.
module add3_frame_acc
    import add3_frame_acc_pkg::*;
#(
    parameter int ADD_LATENCY = 3,
    parameter int Q_BITS      = 32,
    parameter int ACC_BITS    = 40,
    parameter int FRAME_LEN   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    input  logic [Q_BITS-1:0]   i_q,
    input  logic                i_clear,
    output logic [ACC_BITS-1:0] o_sum,
    output logic                o_sum_ovf,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_drop,
    output logic                o_busy
);

    localparam int TAG_DEPTH = adder_total_latency(ADD_LATENCY);
    localparam int CNT_BITS  = $clog2(FRAME_LEN);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(FRAME_LEN - 1);

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [ACC_BITS-1:0] acc;
    logic                acc_ovf;
    logic                tag_al;
    logic [ACC_BITS:0]   add_ext;
    logic                frame_done;

    add3_frame_acc_valid_delay #(
        .DEPTH (TAG_DEPTH)
    ) u_valid_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_clear),
        .i_din   (i_in_valid),
        .o_dout  (tag_al)
    );

    // Extra top bit captures the carry out of the accumulator width.
    assign add_ext    = {1'b0, acc} + {1'b0, ACC_BITS'(i_q)};
    assign frame_done = tag_al && (state == ST_ACCUM) && (cnt == LAST_CNT) && !i_clear;
    assign o_busy     = (state == ST_ACCUM);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (tag_al) begin
            if (state == ST_IDLE) begin
                acc     <= ACC_BITS'(i_q);
                acc_ovf <= 1'b0;
                cnt     <= CNT_BITS'(1);
                state   <= ST_ACCUM;
            end else if (cnt == LAST_CNT) begin
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                acc     <= add_ext[ACC_BITS-1:0];
                acc_ovf <= acc_ovf | add_ext[ACC_BITS];
                cnt     <= cnt + CNT_BITS'(1);
            end
        end
    end

    // Holding register: a completed total is taken only if the slot is free or
    // being emptied this cycle; otherwise the new total is discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sum     <= '0;
            o_sum_ovf <= 1'b0;
            o_valid   <= 1'b0;
            o_drop    <= 1'b0;
        end else begin
            if (frame_done) begin
                if (!o_valid || i_ready) begin
                    o_sum     <= add_ext[ACC_BITS-1:0];
                    o_sum_ovf <= acc_ovf | add_ext[ACC_BITS];
                    o_valid   <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (i_clear) begin
                o_drop <= 1'b0;
            end else if (frame_done && o_valid && !i_ready) begin
                o_drop <= 1'b1;
            end
        end
    end

endmodule
